// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial RAM arbiter: FSM states, access size
// codes and the byte-count lookup.
package mem_arbiter_pkg;

    // Width of the external RAM data bus.
    localparam int unsigned RAM_DW = 8;

    // mem_size encodings; code 3 is handled as a word.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Instruction fetches are always one full word.
    localparam logic [2:0] IF_BYTES = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StIfRd,
        StMemRd,
        StMemWr,
        StDone
    } state_e;

    // Number of byte transfers for a load/store of the given size.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_asm.sv
// Little-endian word assembly register: captures one RAM byte per enabled
// cycle into the selected lane. A lane-0 capture starts a new word and clears
// the upper lanes, so short loads come out zero-extended. The word is held
// until the next capture.
module mem_byte_asm
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        lane,
    input  logic [RAM_DW-1:0] din,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] word_d;

    // Merge the incoming byte into its lane; lane 0 begins a fresh word.
    always_comb begin
        word_d = (lane == 2'd0) ? '0 : word;
        for (int i = 0; i < int'(DATA_W / RAM_DW); i++) begin
            if (lane == 2'(i)) begin
                word_d[i*RAM_DW +: RAM_DW] = din;
            end
        end
    end

    // Capture register, cleared by reset only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
        end else if (en) begin
            word <= word_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM port between instruction fetch
// and load/store. MEM wins ties; accesses are never preempted. rdy_in low
// freezes all state and suppresses RAM writes and done pulses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    input  logic [RAM_DW-1:0] ram_din,
    output logic [RAM_DW-1:0] ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [RAM_DW-1:0] ram_dout_q;
    logic              ram_wr_q;
    logic              if_done_q;
    logic              mem_done_q;

    logic [2:0]        cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [RAM_DW-1:0] wbyte_nxt;
    logic              rd_state;
    logic              cap_en;
    logic [1:0]        cap_lane;

    // Next transfer address/byte and read-capture control.
    always_comb begin
        cnt_nxt   = cnt_q + 3'd1;
        addr_nxt  = base_q + ADDR_W'(cnt_nxt);
        wbyte_nxt = wdata_q[{cnt_nxt[1:0], 3'b000} +: RAM_DW];
        rd_state  = (state_q == StIfRd) || (state_q == StMemRd);
        // ram_din lags ram_a by a cycle, so count k delivers byte k-1.
        cap_en    = rdy_in && rd_state && (cnt_q != 3'd0);
        cap_lane  = 2'(cnt_q - 3'd1);
    end

    mem_byte_asm #(
        .DATA_W (DATA_W)
    ) u_if_asm (
        .clk  (clk),
        .rst  (rst),
        .en   (cap_en && (state_q == StIfRd)),
        .lane (cap_lane),
        .din  (ram_din),
        .word (if_inst)
    );

    mem_byte_asm #(
        .DATA_W (DATA_W)
    ) u_mem_asm (
        .clk  (clk),
        .rst  (rst),
        .en   (cap_en && (state_q == StMemRd)),
        .lane (cap_lane),
        .din  (ram_din),
        .word (mem_rdata)
    );

    // Arbitration FSM with registered RAM-side outputs and done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            n_q        <= 3'd0;
            base_q     <= '0;
            wdata_q    <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else if (rdy_in) begin
            case (state_q)
                StIdle: begin
                    cnt_q <= 3'd0;
                    // The older instruction in MEM must proceed first.
                    if (mem_req) begin
                        base_q  <= mem_addr;
                        n_q     <= byte_count(mem_size);
                        wdata_q <= mem_wdata;
                        ram_a_q <= mem_addr;
                        if (mem_we) begin
                            state_q    <= StMemWr;
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= mem_wdata[RAM_DW-1:0];
                        end else begin
                            state_q <= StMemRd;
                        end
                    end else if (if_req) begin
                        base_q  <= if_addr;
                        n_q     <= IF_BYTES;
                        ram_a_q <= if_addr;
                        state_q <= StIfRd;
                    end
                end
                StIfRd, StMemRd: begin
                    if (cnt_q == n_q) begin
                        state_q    <= StDone;
                        if_done_q  <= (state_q == StIfRd);
                        mem_done_q <= (state_q == StMemRd);
                    end else begin
                        cnt_q   <= cnt_nxt;
                        // Final count only collects the last byte; no new address.
                        ram_a_q <= (cnt_nxt < n_q) ? addr_nxt : '0;
                    end
                end
                StMemWr: begin
                    if (cnt_q == n_q - 3'd1) begin
                        state_q    <= StDone;
                        mem_done_q <= 1'b1;
                        ram_wr_q   <= 1'b0;
                        ram_a_q    <= '0;
                        ram_dout_q <= '0;
                    end else begin
                        cnt_q      <= cnt_nxt;
                        ram_a_q    <= addr_nxt;
                        ram_dout_q <= wbyte_nxt;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    cnt_q      <= 3'd0;
                    if_done_q  <= 1'b0;
                    mem_done_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Gating by rdy_in keeps a pending done alive and stops writes at once.
    assign ram_a        = ram_a_q;
    assign ram_dout     = ram_dout_q;
    assign ram_wr       = ram_wr_q & rdy_in;
    assign if_done      = if_done_q & rdy_in;
    assign mem_done     = mem_done_q & rdy_in;
    assign stallreq_if  = if_req & ~if_done;
    assign stallreq_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte RAM model, scoreboard of expected
// done pulses (kind, data, cycle) and of expected RAM writes.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic [7:0]  ram_din = '0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy_in       (rdy_in),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .if_inst      (if_inst),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .ram_a        (ram_a),
        .ram_wr       (ram_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t        sb[$];
    wr_t         wq[$];
    logic [7:0]  mem [0:4095];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_done_exp = 0;
    int unsigned n_done_seen = 0;
    int unsigned n_wr_exp = 0;
    int unsigned n_wr_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Byte RAM: read data appears one cycle after the address; 4 KiB image.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_din <= mem[ram_a[11:0]];
        if (ram_wr) mem[ram_a[11:0]] = ram_dout;
    end

    // Done scoreboard.
    always @(negedge clk) begin
        if (rst && (if_done || mem_done)) begin
            n_done_seen++;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("done_kind", {31'b0, if_done}, {31'b0, e.is_if});
                check_eq("done_data", e.is_if ? if_inst : mem_rdata, e.data);
                check_eq("done_cycle", cyc, e.cyc);
            end
        end
    end

    // RAM write scoreboard.
    always @(negedge clk) begin
        if (ram_wr) begin
            n_wr_seen++;
            if (wq.size() != 0) begin
                wr_t w;
                w = wq.pop_front();
                check_eq("wr_addr", ram_a, w.a);
                check_eq("wr_data", {24'b0, ram_dout}, {24'b0, w.d});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        wq.push_back(w);
        n_wr_exp++;
    endtask

    task automatic push_done(input bit is_if, input logic [31:0] d, input int unsigned lat);
        exp_t e;
        e.is_if = is_if;
        e.data  = d;
        e.cyc   = cyc + lat;
        sb.push_back(e);
        n_done_exp++;
    endtask

    task automatic issue_if(input logic [31:0] a, input logic [31:0] d, input int unsigned lat);
        if_addr = a;
        if_req  = 1'b1;
        push_done(1'b1, d, lat);
    endtask

    // Stores also expect their byte writes; data is the retained mem_rdata.
    task automatic issue_mem(input logic we, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] d,
                             input int unsigned lat);
        logic [31:0] wtmp;
        int          nb;
        mem_we    = we;
        mem_size  = sz;
        mem_addr  = a;
        mem_wdata = wd;
        mem_req   = 1'b1;
        push_done(1'b0, d, lat);
        if (we) begin
            nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            wtmp = wd;
            for (int i = 0; i < nb; i++) begin
                push_wr(a + 32'(i), wtmp[7:0]);
                wtmp = wtmp >> 8;
            end
        end
    endtask

    task automatic wait_if_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (if_done) begin
                check_eq("stall_if_at_done", {31'b0, stallreq_if}, 32'd0);
                if_req = 1'b0;
                seen   = 1'b1;
            end else begin
                check_eq("stall_if_busy", {31'b0, stallreq_if}, 32'd1);
            end
        end
        check_eq("if_done_seen", {31'b0, seen}, 32'd1);
        if_req = 1'b0;
    endtask

    task automatic wait_mem_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_done) begin
                check_eq("stall_mem_at_done", {31'b0, stallreq_mem}, 32'd0);
                mem_req = 1'b0;
                seen    = 1'b1;
            end else begin
                check_eq("stall_mem_busy", {31'b0, stallreq_mem}, 32'd1);
            end
        end
        check_eq("mem_done_seen", {31'b0, seen}, 32'd1);
        mem_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h10; mem[12'h103] = 8'h00;
        mem[12'h104] = 8'h93; mem[12'h105] = 8'h02; mem[12'h106] = 8'h00; mem[12'h107] = 8'h00;
        mem[12'h200] = 8'hFF;
        mem[12'h204] = 8'h11; mem[12'h205] = 8'h22; mem[12'h206] = 8'h33; mem[12'h207] = 8'h44;
        mem[12'hFFE] = 8'hAA; mem[12'hFFF] = 8'hBB; mem[12'h000] = 8'hCC; mem[12'h001] = 8'hDD;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ram_a", ram_a, 32'd0);
        check_eq("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
        check_eq("rst_ram_dout", {24'b0, ram_dout}, 32'd0);
        check_eq("rst_if_inst", if_inst, 32'd0);
        check_eq("rst_mem_rdata", mem_rdata, 32'd0);
        check_eq("rst_dones", {30'b0, if_done, mem_done}, 32'd0);
        rst = 1'b1;
        tick();

        // Word fetch.
        issue_if(32'h100, 32'h0010_0513, 6);
        wait_if_done();
        tick();

        // Simultaneous requests: MEM byte load first, then the fetch.
        issue_mem(1'b0, 2'd0, 32'h200, 32'h0, 32'h0000_00FF, 3);
        issue_if(32'h100, 32'h0010_0513, 10);
        fork
            wait_mem_done();
            wait_if_done();
        join
        tick();

        // Half store; mem_rdata keeps the previous load.
        issue_mem(1'b1, 2'd1, 32'h300, 32'hDEAD_BEEF, 32'h0000_00FF, 3);
        wait_mem_done();
        tick();

        // MEM request arrives mid-fetch and waits for it to finish.
        issue_if(32'h104, 32'h0000_0293, 6);
        fork
            wait_if_done();
            begin
                tick();
                tick();
                issue_mem(1'b0, 2'd2, 32'h204, 32'h0, 32'h4433_2211, 11);
                wait_mem_done();
            end
        join
        tick();

        // Three-cycle pause at byte 2 of a word store.
        issue_mem(1'b1, 2'd2, 32'h400, 32'hA1B2_C3D4, 32'h4433_2211, 8);
        fork
            wait_mem_done();
            begin
                tick();
                tick();
                tick();
                rdy_in = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_eq("pause_ram_wr", {31'b0, ram_wr}, 32'd0);
                    check_eq("pause_ram_a", ram_a, 32'h402);
                end
                tick();
                rdy_in = 1'b1;
            end
        join
        tick();

        // Reset during byte 1 of a word store: only byte 0 reaches RAM.
        mem_we    = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = 32'h500;
        mem_wdata = 32'h5566_7788;
        mem_req   = 1'b1;
        push_wr(32'h500, 8'h88);
        tick();
        tick();
        rst     = 1'b0;
        mem_req = 1'b0;
        #1;
        check_eq("midrst_ram_wr", {31'b0, ram_wr}, 32'd0);
        check_eq("midrst_mem_done", {31'b0, mem_done}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        check_eq("midrst_mem_rdata", mem_rdata, 32'd0);
        issue_if(32'h100, 32'h0010_0513, 6);
        wait_if_done();
        tick();

        // Fetch wrapping past the top of the address space.
        issue_if(32'hFFFF_FFFE, 32'hDDCC_BBAA, 6);
        wait_if_done();
        tick();

        // Half load, size code 3 as word, byte store, byte load.
        issue_mem(1'b0, 2'd1, 32'h300, 32'h0, 32'h0000_BEEF, 4);
        wait_mem_done();
        tick();
        issue_mem(1'b0, 2'd3, 32'h204, 32'h0, 32'h4433_2211, 6);
        wait_mem_done();
        tick();
        issue_mem(1'b1, 2'd0, 32'h600, 32'h1234_56AB, 32'h4433_2211, 2);
        wait_mem_done();
        tick();
        issue_mem(1'b0, 2'd0, 32'h600, 32'h0, 32'h0000_00AB, 3);
        wait_mem_done();
        repeat (4) tick();

        // RAM image and totals.
        check_eq("img_300", {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]},
                 32'h0000_BEEF);
        check_eq("img_400", {mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]},
                 32'hA1B2_C3D4);
        check_eq("img_500", {mem[12'h503], mem[12'h502], mem[12'h501], mem[12'h500]},
                 32'h0000_0088);
        check_eq("img_600", {mem[12'h603], mem[12'h602], mem[12'h601], mem[12'h600]},
                 32'h0000_00AB);
        check_eq("done_count", n_done_seen, n_done_exp);
        check_eq("write_count", n_wr_seen, n_wr_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
